// File: rtl/pll_sup_pkg.sv
// Shared state encoding and sizing helpers for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  // Timer width large enough to hold n without wrapping.
  function automatic int timer_w(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer, resets to 0.
module sync_2ff (
  input  logic i_clk,
  input  logic i_arst_n,
  input  logic i_d,
  output logic o_q
);

  logic meta;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      meta <= 1'b0;
      o_q  <= 1'b0;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, qualifies lock and gates the downstream reset until lock is stable.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES       = 16,
  parameter int unsigned LOCK_STABLE_CYCLES   = 256,
  parameter int unsigned LOCK_TIMEOUT_CYCLES  = 65536,
  parameter int unsigned EXT_HOLD_CYCLES      = 32,
  parameter int unsigned UNLOCK_FILTER_CYCLES = 4,
  parameter int unsigned MAX_RETRIES          = 8,
  parameter int unsigned CNT_W                = 8
) (
  input  logic             i_clk,
  input  logic             i_arst_n,
  input  logic             i_pll_locked,
  input  logic             i_sw_reset_req,
  output logic             o_pll_reset,
  output logic             o_ext_arst,
  output logic             o_pll_unlocked,
  output logic             o_lock_fail,
  output logic [CNT_W-1:0] o_retry_count,
  output logic [CNT_W-1:0] o_loss_count,
  output logic [1:0]       o_state
);

  localparam int TW = timer_w(max3(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, EXT_HOLD_CYCLES));
  localparam int SW = timer_w(LOCK_STABLE_CYCLES);
  localparam int FW = timer_w(UNLOCK_FILTER_CYCLES);
  localparam int RW = timer_w(MAX_RETRIES);

  localparam logic [TW-1:0] RST_LAST    = TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LAST   = TW'((EXT_HOLD_CYCLES == 0) ? 0 : EXT_HOLD_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [FW-1:0] FILT_LAST   = FW'(UNLOCK_FILTER_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRIES);

  state_t           state, state_nxt;
  logic [TW-1:0]    timer, timer_nxt;
  logic [SW-1:0]    stable, stable_nxt;
  logic [FW-1:0]    filt, filt_nxt;
  logic [RW-1:0]    consec, consec_nxt;
  logic [CNT_W-1:0] retry_nxt, loss_nxt;
  logic             lock_fail_nxt;
  logic             locked_s;
  logic             qualified, timeout, loss, restart;

  sync_2ff u_lock_sync (
    .i_clk    (i_clk),
    .i_arst_n (i_arst_n),
    .i_d      (i_pll_locked),
    .o_q      (locked_s)
  );

  always_comb begin
    state_nxt = state;
    qualified = 1'b0;
    timeout   = 1'b0;
    loss      = 1'b0;
    case (state)
      PLL_RST:   if (timer == RST_LAST) state_nxt = WAIT_LOCK;
      WAIT_LOCK: begin
        if (locked_s && stable == STABLE_LAST) begin
          qualified = 1'b1;
          state_nxt = HOLD;
        end else if (timer == TO_LAST) begin
          timeout   = 1'b1;
          state_nxt = PLL_RST;
        end
      end
      HOLD: begin
        if (!locked_s)               state_nxt = PLL_RST;
        else if (timer == HOLD_LAST) state_nxt = RUN;
      end
      RUN: begin
        if (!locked_s && filt == FILT_LAST) begin
          loss      = 1'b1;
          state_nxt = PLL_RST;
        end
      end
      default: state_nxt = PLL_RST;
    endcase

    // Software restart overrides the transition but timeout/loss events are still counted.
    if (i_sw_reset_req) state_nxt = PLL_RST;
    restart = i_sw_reset_req || (state_nxt != state);

    timer_nxt  = (restart || state == RUN) ? '0 : timer + 1'b1;
    stable_nxt = (!restart && state == WAIT_LOCK && locked_s) ? stable + 1'b1 : '0;
    filt_nxt   = (!restart && state == RUN && !locked_s) ? filt + 1'b1 : '0;

    consec_nxt = consec;
    if (qualified && !i_sw_reset_req)        consec_nxt = '0;
    else if (timeout && consec != RETRY_LIMIT) consec_nxt = consec + 1'b1;

    lock_fail_nxt = o_lock_fail || (timeout && consec_nxt == RETRY_LIMIT);
    retry_nxt     = (timeout && o_retry_count != '1) ? o_retry_count + 1'b1 : o_retry_count;
    loss_nxt      = (loss && o_loss_count != '1) ? o_loss_count + 1'b1 : o_loss_count;
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state          <= PLL_RST;
      timer          <= '0;
      stable         <= '0;
      filt           <= '0;
      consec         <= '0;
      o_lock_fail    <= 1'b0;
      o_retry_count  <= '0;
      o_loss_count   <= '0;
      o_pll_reset    <= 1'b1;
      o_ext_arst     <= 1'b1;
      o_pll_unlocked <= 1'b1;
    end else begin
      state          <= state_nxt;
      timer          <= timer_nxt;
      stable         <= stable_nxt;
      filt           <= filt_nxt;
      consec         <= consec_nxt;
      o_lock_fail    <= lock_fail_nxt;
      o_retry_count  <= retry_nxt;
      o_loss_count   <= loss_nxt;
      o_pll_reset    <= (state_nxt == PLL_RST);
      o_ext_arst     <= (state_nxt != RUN);
      o_pll_unlocked <= (state_nxt != RUN);
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench: main instance uses default timing, a second instance uses short lock timeouts.
module tb_pll_lock_supervisor;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       arst_n, locked, sw;
  logic       pll_reset, ext_arst, unlocked, lock_fail;
  logic [7:0] retry, loss;
  logic [1:0] state;

  logic       arst_b_n, locked_b, sw_b;
  logic       b_pll_reset, b_ext_arst, b_unlocked, b_lock_fail;
  logic [7:0] b_retry, b_loss;
  logic [1:0] b_state;

  int tests = 0;
  int fails = 0;

  pll_lock_supervisor dut (
    .i_clk(clk), .i_arst_n(arst_n), .i_pll_locked(locked), .i_sw_reset_req(sw),
    .o_pll_reset(pll_reset), .o_ext_arst(ext_arst), .o_pll_unlocked(unlocked),
    .o_lock_fail(lock_fail), .o_retry_count(retry), .o_loss_count(loss), .o_state(state)
  );

  pll_lock_supervisor #(
    .LOCK_STABLE_CYCLES (10),
    .LOCK_TIMEOUT_CYCLES(100)
  ) dut_b (
    .i_clk(clk), .i_arst_n(arst_b_n), .i_pll_locked(locked_b), .i_sw_reset_req(sw_b),
    .o_pll_reset(b_pll_reset), .o_ext_arst(b_ext_arst), .o_pll_unlocked(b_unlocked),
    .o_lock_fail(b_lock_fail), .o_retry_count(b_retry), .o_loss_count(b_loss), .o_state(b_state)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Short-timeout instance: 16-cycle PLL reset + 100-cycle timeout = 116 cycles per retry.
  task automatic test_retries;
    if (b_pll_reset !== 1'b1 || b_lock_fail !== 1'b0 || b_retry !== 8'd0 || b_state !== 2'd0) begin
      $display("FAIL b_reset_vals got rst=%0b fail=%0b retry=%0d st=%0d exp 1 0 0 0",
               b_pll_reset, b_lock_fail, b_retry, b_state); fails++; end
    tests++;
    tick(1);
    arst_b_n = 1'b1;
    tick(16);
    if (b_state !== 2'd1 || b_pll_reset !== 1'b0) begin
      $display("FAIL b_wait_entry got st=%0d rst=%0b exp 1 0", b_state, b_pll_reset); fails++; end
    tests++;
    tick(100);
    if (b_retry !== 8'd1 || b_state !== 2'd0) begin
      $display("FAIL b_first_timeout got retry=%0d st=%0d exp 1 0", b_retry, b_state); fails++; end
    tests++;
    tick(811);
    if (b_retry !== 8'd7 || b_lock_fail !== 1'b0) begin
      $display("FAIL b_before_8th got retry=%0d fail=%0b exp 7 0", b_retry, b_lock_fail); fails++; end
    tests++;
    tick(1);
    if (b_retry !== 8'd8 || b_lock_fail !== 1'b1) begin
      $display("FAIL b_8th_timeout got retry=%0d fail=%0b exp 8 1", b_retry, b_lock_fail); fails++; end
    tests++;
    tick(116);
    if (b_retry !== 8'd9 || b_lock_fail !== 1'b1 || b_state !== 2'd0) begin
      $display("FAIL b_9th_timeout got retry=%0d fail=%0b st=%0d exp 9 1 0",
               b_retry, b_lock_fail, b_state); fails++; end
    tests++;
    locked_b = 1'b1;
    tick(57);
    if (b_state !== 2'd2 || b_ext_arst !== 1'b1) begin
      $display("FAIL b_hold got st=%0d ext=%0b exp 2 1", b_state, b_ext_arst); fails++; end
    tests++;
    tick(1);
    if (b_state !== 2'd3 || b_unlocked !== 1'b0 || b_lock_fail !== 1'b1 || b_retry !== 8'd9) begin
      $display("FAIL b_run_after_fail got st=%0d unl=%0b fail=%0b retry=%0d exp 3 0 1 9",
               b_state, b_unlocked, b_lock_fail, b_retry); fails++; end
    tests++;
  endtask

  // Software request lands on the same edge the unlock filter expires.
  task automatic test_sw_collision;
    locked_b = 1'b0;
    tick(4);
    locked_b = 1'b1;
    tick(1);
    sw_b = 1'b1;
    tick(1);
    sw_b = 1'b0;
    if (b_state !== 2'd0 || b_loss !== 8'd1 || b_ext_arst !== 1'b1) begin
      $display("FAIL b_sw_with_loss got st=%0d loss=%0d ext=%0b exp 0 1 1",
               b_state, b_loss, b_ext_arst); fails++; end
    tests++;
  endtask

  task automatic test_reset;
    if (pll_reset !== 1'b1 || ext_arst !== 1'b1 || unlocked !== 1'b1 || lock_fail !== 1'b0 ||
        retry !== 8'd0 || loss !== 8'd0 || state !== 2'd0) begin
      $display("FAIL reset_vals got %0b%0b%0b%0b r=%0d l=%0d st=%0d exp 1110 r=0 l=0 st=0",
               pll_reset, ext_arst, unlocked, lock_fail, retry, loss, state); fails++; end
    tests++;
    arst_n = 1'b1;
    tick(15);
    if (pll_reset !== 1'b1) begin
      $display("FAIL pll_rst_15 got %0b exp 1", pll_reset); fails++; end
    tests++;
    tick(1);
    if (pll_reset !== 1'b0 || state !== 2'd1) begin
      $display("FAIL pll_rst_16 got rst=%0b st=%0d exp 0 1", pll_reset, state); fails++; end
    tests++;
    tick(256);
    if (state !== 2'd2 || ext_arst !== 1'b1) begin
      $display("FAIL qualify got st=%0d ext=%0b exp 2 1", state, ext_arst); fails++; end
    tests++;
    tick(31);
    if (ext_arst !== 1'b1 || unlocked !== 1'b1) begin
      $display("FAIL hold_end got ext=%0b unl=%0b exp 1 1", ext_arst, unlocked); fails++; end
    tests++;
    tick(1);
    if (ext_arst !== 1'b0 || unlocked !== 1'b0 || state !== 2'd3 || retry !== 8'd0 || loss !== 8'd0) begin
      $display("FAIL run_entry got ext=%0b unl=%0b st=%0d r=%0d l=%0d exp 0 0 3 0 0",
               ext_arst, unlocked, state, retry, loss); fails++; end
    tests++;
  endtask

  task automatic test_run_filter;
    locked = 1'b0;
    tick(3);
    locked = 1'b1;
    tick(5);
    if (state !== 2'd3 || ext_arst !== 1'b0 || loss !== 8'd0) begin
      $display("FAIL filter_3 got st=%0d ext=%0b loss=%0d exp 3 0 0", state, ext_arst, loss); fails++; end
    tests++;
    locked = 1'b0;
    tick(4);
    locked = 1'b1;
    tick(1);
    if (state !== 2'd3 || ext_arst !== 1'b0) begin
      $display("FAIL filter_4_pre got st=%0d ext=%0b exp 3 0", state, ext_arst); fails++; end
    tests++;
    tick(1);
    if (state !== 2'd0 || ext_arst !== 1'b1 || unlocked !== 1'b1 || pll_reset !== 1'b1 || loss !== 8'd1) begin
      $display("FAIL filter_4 got st=%0d ext=%0b unl=%0b rst=%0b loss=%0d exp 0 1 1 1 1",
               state, ext_arst, unlocked, pll_reset, loss); fails++; end
    tests++;
    tick(15);
    if (pll_reset !== 1'b1) begin
      $display("FAIL loss_pulse_15 got %0b exp 1", pll_reset); fails++; end
    tests++;
    tick(1);
    if (pll_reset !== 1'b0 || state !== 2'd1) begin
      $display("FAIL loss_pulse_16 got rst=%0b st=%0d exp 0 1", pll_reset, state); fails++; end
    tests++;
  endtask

  // Glitch timed so the stable counter reads 200 when the low sample reaches the FSM.
  task automatic test_glitch;
    tick(198);
    locked = 1'b0;
    tick(1);
    locked = 1'b1;
    tick(57);
    if (state !== 2'd1) begin
      $display("FAIL glitch_no_early got st=%0d exp 1", state); fails++; end
    tests++;
    tick(200);
    if (state !== 2'd1) begin
      $display("FAIL glitch_255 got st=%0d exp 1", state); fails++; end
    tests++;
    tick(1);
    if (state !== 2'd2) begin
      $display("FAIL glitch_256 got st=%0d exp 2", state); fails++; end
    tests++;
  endtask

  task automatic test_sw_reset;
    tick(32);
    if (state !== 2'd3) begin
      $display("FAIL sw_pre_run got st=%0d exp 3", state); fails++; end
    tests++;
    sw = 1'b1;
    tick(1);
    sw = 1'b0;
    if (state !== 2'd0 || ext_arst !== 1'b1 || pll_reset !== 1'b1 || loss !== 8'd1 ||
        retry !== 8'd0 || lock_fail !== 1'b0) begin
      $display("FAIL sw_reset got st=%0d ext=%0b rst=%0b l=%0d r=%0d f=%0b exp 0 1 1 1 0 0",
               state, ext_arst, pll_reset, loss, retry, lock_fail); fails++; end
    tests++;
    tick(15);
    if (state !== 2'd0) begin
      $display("FAIL sw_rst_15 got st=%0d exp 0", state); fails++; end
    tests++;
    tick(1);
    if (state !== 2'd1) begin
      $display("FAIL sw_rst_16 got st=%0d exp 1", state); fails++; end
    tests++;
  endtask

  task automatic test_arst_in_hold;
    tick(256);
    if (state !== 2'd2) begin
      $display("FAIL arst_pre_hold got st=%0d exp 2", state); fails++; end
    tests++;
    tick(5);
    arst_n = 1'b0;
    #1;
    if (pll_reset !== 1'b1 || ext_arst !== 1'b1 || unlocked !== 1'b1 || lock_fail !== 1'b0 ||
        retry !== 8'd0 || loss !== 8'd0 || state !== 2'd0) begin
      $display("FAIL async_reset got %0b%0b%0b%0b r=%0d l=%0d st=%0d exp 1110 r=0 l=0 st=0",
               pll_reset, ext_arst, unlocked, lock_fail, retry, loss, state); fails++; end
    tests++;
  endtask

  initial begin
    arst_n   = 1'b0;
    locked   = 1'b1;
    sw       = 1'b0;
    arst_b_n = 1'b0;
    locked_b = 1'b0;
    sw_b     = 1'b0;
    tick(2);
    test_retries();
    test_sw_collision();
    test_reset();
    test_run_filter();
    test_glitch();
    test_sw_reset();
    test_arst_in_hold();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
